// File: rtl/uart_frame_ctrl_if.sv
// Payload stream from the frame controller to the FSK modulator (valid/ready, last-byte marker).
interface uart_frame_ctrl_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/uart_frame_ctrl.sv
// Parses SYNC/LEN/PAYLOAD frames from the UART receiver and replays the payload on a stream.
// Define FRAME_CHKSUM_EN to require a trailing XOR checksum byte (CHK state, error code 2).
module uart_frame_ctrl #(
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_tick,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_data,
  uart_frame_ctrl_if.master        out_if,
  output logic                     frame_done,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic                     busy
);
  localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);
  localparam logic [15:0] TermCnt = 16'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
`ifdef FRAME_CHKSUM_EN
    StChk,
`endif
    StSend
  } state_e;

  state_e            state_q;
  logic [7:0]        len_q;
  logic [IdxW-1:0]   wr_idx_q;
  logic [IdxW-1:0]   rd_idx_q;
  logic [15:0]       cnt_q;
`ifdef FRAME_CHKSUM_EN
  logic [7:0]        chk_q;
`endif
  logic [7:0]        buf_mem [MAX_LEN];

  logic [7:0]        len_m1;
  logic [IdxW-1:0]   rd_next;
  logic              wr_last;
  logic              in_frame;
  logic              timed_out;
  logic [7:0]        first_byte;

  assign len_m1    = len_q - 8'd1;
  assign rd_next   = rd_idx_q + 1'b1;
  assign wr_last   = (8'(wr_idx_q) == len_m1);
  assign in_frame  = (state_q != StIdle) && (state_q != StSend);
  // A byte in the same cycle as the terminal tick wins and clears the counter.
  assign timed_out = in_frame && s_tick && !rx_done_tick && (cnt_q == TermCnt);
  // A 1-byte frame enters SEND while its only byte is still on rx_data.
  assign first_byte = (state_q == StPayload && wr_idx_q == '0) ? rx_data : buf_mem[0];
  assign busy      = (state_q != StIdle);

  // Buffer has no reset: validity is defined by len_q and the indices alone.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StPayload && rx_done_tick) begin
      buf_mem[wr_idx_q] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      len_q            <= '0;
      wr_idx_q         <= '0;
      rd_idx_q         <= '0;
      cnt_q            <= '0;
`ifdef FRAME_CHKSUM_EN
      chk_q            <= '0;
`endif
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
      frame_done       <= 1'b0;
      err_valid        <= 1'b0;
      err_code         <= '0;
    end else begin
      frame_done <= 1'b0;
      err_valid  <= 1'b0;

      if (!in_frame || rx_done_tick) begin
        cnt_q <= '0;
      end else if (s_tick) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (timed_out) begin
        err_valid <= 1'b1;
        err_code  <= 2'd3;
        state_q   <= StIdle;
        cnt_q     <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rx_done_tick && rx_data == SYNC_BYTE) state_q <= StLen;
          end
          StLen: begin
            if (rx_done_tick) begin
              if (rx_data == 8'd0 || rx_data > MaxLenB) begin
                err_valid <= 1'b1;
                err_code  <= 2'd1;
                state_q   <= StIdle;
              end else begin
                len_q    <= rx_data;
                wr_idx_q <= '0;
`ifdef FRAME_CHKSUM_EN
                chk_q    <= rx_data;
`endif
                state_q  <= StPayload;
              end
            end
          end
          StPayload: begin
            if (rx_done_tick) begin
              wr_idx_q <= wr_idx_q + 1'b1;
`ifdef FRAME_CHKSUM_EN
              chk_q    <= chk_q ^ rx_data;
              if (wr_last) state_q <= StChk;
`else
              if (wr_last) begin
                state_q          <= StSend;
                rd_idx_q         <= '0;
                out_if.out_valid <= 1'b1;
                out_if.out_data  <= first_byte;
                out_if.out_last  <= (len_q == 8'd1);
              end
`endif
            end
          end
`ifdef FRAME_CHKSUM_EN
          StChk: begin
            if (rx_done_tick) begin
              if (rx_data == chk_q) begin
                state_q          <= StSend;
                rd_idx_q         <= '0;
                out_if.out_valid <= 1'b1;
                out_if.out_data  <= first_byte;
                out_if.out_last  <= (len_q == 8'd1);
              end else begin
                err_valid <= 1'b1;
                err_code  <= 2'd2;
                state_q   <= StIdle;
              end
            end
          end
`endif
          StSend: begin
            // Bytes arriving while replaying are dropped and flagged as overrun.
            if (rx_done_tick) begin
              err_valid <= 1'b1;
              err_code  <= 2'd0;
            end
            if (out_if.out_valid && out_if.out_ready) begin
              if (out_if.out_last) begin
                frame_done       <= 1'b1;
                out_if.out_valid <= 1'b0;
                out_if.out_last  <= 1'b0;
                out_if.out_data  <= '0;
                state_q          <= StIdle;
              end else begin
                rd_idx_q        <= rd_next;
                out_if.out_data <= buf_mem[rd_next];
                out_if.out_last <= (8'(rd_next) == len_m1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end
endmodule
